// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: count width and
// parameter legality predicates used at elaboration time.
package sync_fifo_pkg;

  // Width of the occupancy counter: must represent 0..depth inclusive.
  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when v is a power of two and at least 2.
  function automatic bit is_pow2(int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Full legality check of the FIFO parameter set.
  function automatic bit params_ok(int width, int depth, int af, int ae);
    return (width >= 1) && is_pow2(depth) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH storage array: synchronous write port, asynchronous read port.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on an accepted write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow flags and optional first-word-fall-through.
//
// Handshake: a write is accepted when wr & !full, a read when rd & !empty.
// Both flags are the pre-edge values, so a read in the same cycle never
// makes room for a write when full, and a write never feeds a read when
// empty. An accepted write and read may happen in the same cycle.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [WIDTH-1:0]          din,
  input  logic                      rd,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo: illegal parameter set");
  end

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rdata;
  logic             wa;
  logic             ra;

  assign full         = (cnt == CW'(DEPTH));
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= CW'(AF_LEVEL));
  assign almost_empty = (cnt <= CW'(AE_LEVEL));
  assign count        = cnt;

  assign wa = wr & ~full;
  assign ra = rd & ~empty;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wa),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Pointers wrap naturally; count tracks occupancy and tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wa) wptr <= wptr + AW'(1);
      if (ra) rptr <= rptr + AW'(1);
      case ({wa, ra})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags: a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full)   overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd & empty)   underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally; don't-care while empty.
    assign dout = rdata;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;

    // Registered read data: loads the head word on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
      if (rst)     dout_q <= '0;
      else if (ra) dout_q <= rdata;
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one registered-read instance and one FWFT instance
// share the same stimulus and are checked against a queue-based model.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wr;
  logic [WIDTH-1:0] din;
  logic             rd;
  logic             clr_err;

  logic [WIDTH-1:0] dout0, dout1;
  logic             full0, empty0, af0, ae0, ovf0, udf0;
  logic             full1, empty1, af1, ae1, ovf1, udf1;
  logic [CW-1:0]    count0, count1;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .clr_err(clr_err),
    .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .clr_err(clr_err),
    .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] mq[$];      // FIFO contents, head at index 0
  logic [WIDTH-1:0] exp_q[$];   // expected registered-dout updates
  bit               m_ovf = 1'b0;
  bit               m_udf = 1'b0;
  int               errors = 0;
  int               checks = 0;
  bit               mon_en = 1'b0;

  // Apply one clock edge's worth of behaviour to the model using pre-edge inputs.
  task automatic model_edge();
    bit m_full, m_empty, acc_w, acc_r;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      exp_q.push_back('0);
    end else begin
      acc_w = wr && !m_full;
      acc_r = rd && !m_empty;
      if (acc_r) exp_q.push_back(mq.pop_front());
      if (acc_w) mq.push_back(din);
      if (wr && m_full)  m_ovf = 1'b1;
      else if (clr_err)  m_ovf = 1'b0;
      if (rd && m_empty) m_udf = 1'b1;
      else if (clr_err)  m_udf = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic w, input logic [WIDTH-1:0] d,
                      input logic rq, input logic c);
    rst = r; wr = w; din = d; rd = rq; clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  logic [WIDTH-1:0] last_dout = '0;

  // Sample away from the active edge and compare everything against the model.
  always @(negedge clk) begin
    int n;
    if (mon_en) begin
      n = mq.size();
      while (exp_q.size() > 0) last_dout = exp_q.pop_front();
      chk("dout_reg", dout0, last_dout);
      if (n > 0) chk("dout_fwft", dout1, mq[0]);
      chk("count0", count0, n);
      chk("count1", count1, n);
      chk("full0", full0, n == DEPTH);
      chk("full1", full1, n == DEPTH);
      chk("empty0", empty0, n == 0);
      chk("empty1", empty1, n == 0);
      chk("af0", af0, n >= 14);
      chk("af1", af1, n >= 14);
      chk("ae0", ae0, n <= 2);
      chk("ae1", ae1, n <= 2);
      chk("overflow0", ovf0, m_ovf);
      chk("overflow1", ovf1, m_ovf);
      chk("underflow0", udf0, m_udf);
      chk("underflow1", udf1, m_udf);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; wr = 1'b1; rd = 1'b1; din = '0; clr_err = 1'b0;
    mon_en = 1'b1;

    // Reset held with wr/rd asserted
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    idle(1);

    // Fill 0x00..0x0F, then overflow with 0xAA, then clear
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, WIDTH'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_after_extra_write", ovf0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", ovf0, 1'b0);

    // Drain 16 words plus one underflowing read
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("udf_after_extra_read", udf0, 1'b1);
    chk("dout_holds_last", dout0, 8'h0F);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Simultaneous read/write at count 5, across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h40 + WIDTH'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h80 + WIDTH'(i), 1'b1, 1'b0);
    chk("count_steady_5", count0, 5);

    // Simultaneous read/write when full
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'hC0 + WIDTH'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_rw_count", count0, 15);

    // Simultaneous read/write when empty
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_rw_count", count0, 1);
    chk("fwft_head_5a", dout1, 8'h5A);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // FWFT: word visible without a read, then popped
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Mid-operation reset with a write alongside
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h10 + WIDTH'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("reset_mid_count", count0, 0);
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("after_reset_read", dout0, 8'h33);

    // Randomised traffic with shifting write/read bias
    for (int ph = 0; ph < 6; ph++) begin
      int wbias, rbias;
      wbias = (ph % 3 == 0) ? 8 : (ph % 3 == 1) ? 3 : 5;
      rbias = (ph % 3 == 0) ? 3 : (ph % 3 == 1) ? 8 : 5;
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 9) < wbias),
             WIDTH'($urandom()),
             ($urandom_range(0, 9) < rbias),
             ($urandom_range(0, 9) == 0));
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
